// File: rtl/tri_bbox_scanner.sv
// Bounding-box point generator for the point-in-triangle stage: latches three vertices, walks the
// box in row-major order under valid/ready flow control and counts the pixels reported inside.
module tri_bbox_scanner #(
   parameter int unsigned W  = 11,
   parameter int unsigned CW = 23
) (
   input  logic          CLK,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  v1x,
   input  logic [W-1:0]  v1y,
   input  logic [W-1:0]  v2x,
   input  logic [W-1:0]  v2y,
   input  logic [W-1:0]  v3x,
   input  logic [W-1:0]  v3y,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  point_x,
   output logic [W-1:0]  point_y,
   input  logic          in_tri,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [W-1:0]  pix_x,
   output logic [W-1:0]  pix_y,
   output logic          pix_inside,
   output logic [CW-1:0] inside_count,
   output logic [W-1:0]  vert_x1,
   output logic [W-1:0]  vert_y1,
   output logic [W-1:0]  vert_x2,
   output logic [W-1:0]  vert_y2,
   output logic [W-1:0]  vert_x3,
   output logic [W-1:0]  vert_y3
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

   state_t       state;
   logic [W-1:0] xmin, xmax, ymin, ymax;
   logic [W-1:0] box_xmin, box_xmax, box_ymin, box_ymax;
   logic         xfer;

   // Unsigned three-way min/max of the incoming vertices, used only when a start is accepted.
   always_comb begin
      box_xmin = (v1x < v2x) ? v1x : v2x;
      if (v3x < box_xmin) box_xmin = v3x;
      box_xmax = (v1x > v2x) ? v1x : v2x;
      if (v3x > box_xmax) box_xmax = v3x;
      box_ymin = (v1y < v2y) ? v1y : v2y;
      if (v3y < box_ymin) box_ymin = v3y;
      box_ymax = (v1y > v2y) ? v1y : v2y;
      if (v3y > box_ymax) box_ymax = v3y;
   end

   assign xfer       = pix_valid & pix_ready;
   assign pix_x      = point_x;
   assign pix_y      = point_y;
   assign pix_inside = in_tri & pix_valid;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state        <= StIdle;
         busy         <= 1'b0;
         done         <= 1'b0;
         pix_valid    <= 1'b0;
         point_x      <= '0;
         point_y      <= '0;
         inside_count <= '0;
         xmin         <= '0;
         xmax         <= '0;
         ymin         <= '0;
         ymax         <= '0;
         vert_x1      <= '0;
         vert_y1      <= '0;
         vert_x2      <= '0;
         vert_y2      <= '0;
         vert_x3      <= '0;
         vert_y3      <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  vert_x1      <= v1x;
                  vert_y1      <= v1y;
                  vert_x2      <= v2x;
                  vert_y2      <= v2y;
                  vert_x3      <= v3x;
                  vert_y3      <= v3y;
                  xmin         <= box_xmin;
                  xmax         <= box_xmax;
                  ymin         <= box_ymin;
                  ymax         <= box_ymax;
                  point_x      <= box_xmin;
                  point_y      <= box_ymin;
                  inside_count <= '0;
                  busy         <= 1'b1;
                  pix_valid    <= 1'b1;
                  state        <= StScan;
               end
            end
            StScan: begin
               if (xfer) begin
                  if (in_tri) inside_count <= inside_count + CW'(1);
                  // Increments stay in range because point never exceeds the box maxima.
                  if (point_x < xmax) begin
                     point_x <= point_x + W'(1);
                  end else if (point_y < ymax) begin
                     point_x <= xmin;
                     point_y <= point_y + W'(1);
                  end else begin
                     busy      <= 1'b0;
                     pix_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= StDone;
                  end
               end
            end
            StDone: begin
               done  <= 1'b0;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Randomised bench for tri_bbox_scanner: a pixel-list model of each scan is checked against the
// DUT on every falling edge, with literal expectations for the hand-worked triangles.
module tb_tri_bbox_scanner;
   localparam int unsigned W  = 11;
   localparam int unsigned CW = 23;

   logic          clk = 1'b0;
   logic          rst, start, in_tri, pix_ready;
   logic [W-1:0]  v1x, v1y, v2x, v2y, v3x, v3y;
   logic          busy, done, pix_valid, pix_inside;
   logic [W-1:0]  point_x, point_y, pix_x, pix_y;
   logic [W-1:0]  vert_x1, vert_y1, vert_x2, vert_y2, vert_x3, vert_y3;
   logic [CW-1:0] inside_count;

   int n_chk = 0, n_fail = 0, n_done = 0;
   int cyc = 0, start_cyc = 0, done_cyc = 0;
   int tri_mode = 0, rdy_mode = 0, rp = 0;

   // Model: 0 idle, 1 scanning, 2 done pulse
   int m_st = 0;
   bit armed = 0, post_reset = 0;
   int exp_count = 0;
   logic [2*W-1:0] q[$];
   logic [2*W-1:0] log_q[$];
   logic [6*W-1:0] m_vert = '0;

   tri_bbox_scanner #(.W(W), .CW(CW)) dut (
      .CLK(clk), .rst(rst), .start(start),
      .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
      .busy(busy), .done(done), .point_x(point_x), .point_y(point_y), .in_tri(in_tri),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
      .pix_inside(pix_inside), .inside_count(inside_count),
      .vert_x1(vert_x1), .vert_y1(vert_y1), .vert_x2(vert_x2), .vert_y2(vert_y2),
      .vert_x3(vert_x3), .vert_y3(vert_y3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic tri_fn(input int mode, input logic [W-1:0] x, input logic [W-1:0] y);
      int xi, yi;
      xi = int'(x);
      yi = int'(y);
      case (mode)
         0:       return (xi + yi <= 10);
         1:       return 1'b1;
         default: return ((xi * 3 + yi * 5) % 7) < 3;
      endcase
   endfunction

   assign in_tri = tri_fn(tri_mode, point_x, point_y);

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Ready generator: always-on, 1,0,0,1 repeating, or random.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       pix_ready = 1'b1;
         1:       begin pix_ready = (rp % 4 == 0) || (rp % 4 == 3); rp++; end
         default: pix_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Compare process and model advance, both at the falling edge.
   always @(negedge clk) begin
      logic [2*W-1:0] f;
      int xs[3], ys[3], xlo, xhi, ylo, yhi;
      logic exp_in;
      if (armed) begin
         chk("busy", 96'(busy), 96'(m_st == 1));
         chk("pix_valid", 96'(pix_valid), 96'(m_st == 1));
         chk("done", 96'(done), 96'(m_st == 2));
         chk("inside_count", 96'(inside_count), 96'(exp_count));
         chk("vertices", 96'({vert_x1, vert_y1, vert_x2, vert_y2, vert_x3, vert_y3}),
             96'(m_vert));
         exp_in = 1'b0;
         if (m_st == 1) begin
            if (q.size() == 0) begin
               chk("beat_underflow", 96'(1), 96'(0));
            end else begin
               chk("pix_xy", 96'({pix_x, pix_y}), 96'(q[0]));
               exp_in = tri_fn(tri_mode, q[0][2*W-1:W], q[0][W-1:0]);
            end
         end
         chk("pix_inside", 96'(pix_inside), 96'(exp_in));
         if (post_reset)
            chk("reset_points", 96'({point_x, point_y, pix_x, pix_y}), 96'(0));
         if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
         end
      end
      post_reset = 0;
      if (rst) begin
         m_st = 0; exp_count = 0; m_vert = '0; q.delete();
         post_reset = 1; armed = 1;
      end else if (armed) begin
         case (m_st)
            0: if (start) begin
               xs = '{int'(v1x), int'(v2x), int'(v3x)};
               ys = '{int'(v1y), int'(v2y), int'(v3y)};
               xlo = xs[0]; xhi = xs[0]; ylo = ys[0]; yhi = ys[0];
               for (int i = 1; i < 3; i++) begin
                  if (xs[i] < xlo) xlo = xs[i];
                  if (xs[i] > xhi) xhi = xs[i];
                  if (ys[i] < ylo) ylo = ys[i];
                  if (ys[i] > yhi) yhi = ys[i];
               end
               q.delete(); log_q.delete();
               for (int y = ylo; y <= yhi; y++)
                  for (int x = xlo; x <= xhi; x++) q.push_back({W'(x), W'(y)});
               m_vert = {v1x, v1y, v2x, v2y, v3x, v3y};
               exp_count = 0;
               m_st = 1;
            end
            1: if (pix_ready && q.size() > 0) begin
               f = q.pop_front();
               log_q.push_back(f);
               if (tri_fn(tri_mode, f[2*W-1:W], f[W-1:0])) exp_count++;
               if (q.size() == 0) m_st = 2;
            end
            default: m_st = 0;
         endcase
      end
   end

   task automatic set_verts(input int ax, ay, bx, by, cx, cy);
      v1x = W'(ax); v1y = W'(ay); v2x = W'(bx); v2y = W'(by); v3x = W'(cx); v3y = W'(cy);
   endtask

   task automatic launch(input int ax, ay, bx, by, cx, cy);
      set_verts(ax, ay, bx, by, cx, cy);
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int budget = 5000;
      while (m_st != 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      if (budget == 0) chk("scan_timeout", 96'(0), 96'(1));
   endtask

   task automatic check_basic(input string tag, input int d0);
      chk({tag, "_beats"}, 96'(log_q.size()), 96'(121));
      chk({tag, "_model_count"}, 96'(exp_count), 96'(66));
      chk({tag, "_count"}, 96'(inside_count), 96'(66));
      chk({tag, "_first"}, 96'(log_q[0]), 96'({W'(0), W'(0)}));
      chk({tag, "_wrap"}, 96'(log_q[11]), 96'({W'(0), W'(1)}));
      chk({tag, "_last"}, 96'(log_q[120]), 96'({W'(10), W'(10)}));
      chk({tag, "_done_pulses"}, 96'(n_done - d0), 96'(1));
   endtask

   initial begin
      int d0, budget, base, bx, by;
      rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
      set_verts(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Basic scan, then the same triangle under 1,0,0,1 backpressure
      tri_mode = 0; rdy_mode = 0; d0 = n_done;
      launch(0, 0, 10, 0, 0, 10); wait_idle();
      check_basic("basic", d0);
      rdy_mode = 1; rp = 0; d0 = n_done;
      launch(0, 0, 10, 0, 0, 10); wait_idle();
      check_basic("backpressure", d0);

      // Degenerate single point
      tri_mode = 1; rdy_mode = 0; d0 = n_done;
      launch(5, 7, 5, 7, 5, 7); wait_idle();
      chk("degen_beats", 96'(log_q.size()), 96'(1));
      chk("degen_point", 96'(log_q[0]), 96'({W'(5), W'(7)}));
      chk("degen_count", 96'(inside_count), 96'(1));
      chk("degen_done_latency", 96'(done_cyc - start_cyc), 96'(2));
      chk("degen_done_pulses", 96'(n_done - d0), 96'(1));

      // Unordered vertices, random ready
      tri_mode = 2; rdy_mode = 2;
      launch(15, 15, 30, 0, 15, 0); wait_idle();
      chk("unord_beats", 96'(log_q.size()), 96'(256));
      chk("unord_first", 96'(log_q[0]), 96'({W'(15), W'(0)}));
      chk("unord_row_end", 96'(log_q[15]), 96'({W'(30), W'(0)}));
      chk("unord_row_wrap", 96'(log_q[16]), 96'({W'(15), W'(1)}));

      // Reset during beat 40, then a clean rescan
      tri_mode = 0; rdy_mode = 0; d0 = n_done;
      launch(0, 0, 10, 0, 0, 10);
      budget = 500;
      while (log_q.size() < 40 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      if (budget == 0) chk("reset_wait_timeout", 96'(0), 96'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_count", 96'(inside_count), 96'(0));
      chk("reset_valid", 96'(pix_valid), 96'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("reset_no_done", 96'(n_done - d0), 96'(0));
      d0 = n_done;
      launch(0, 0, 10, 0, 0, 10); wait_idle();
      check_basic("rescan", d0);

      // Start pulsed mid-scan with other vertices is ignored
      d0 = n_done;
      launch(0, 0, 10, 0, 0, 10);
      repeat (20) @(posedge clk);
      #1;
      set_verts(100, 100, 200, 5, 7, 300);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();
      check_basic("busy_start", d0);

      // Random small triangles, one pinned at the top coordinate
      tri_mode = 2; rdy_mode = 2;
      for (int i = 0; i < 8; i++) begin
         base = (i == 0) ? 2032 : int'($urandom_range(0, 2000));
         bx = base + int'($urandom_range(0, 15));
         by = base + int'($urandom_range(0, 15));
         if (i == 0) begin bx = 2047; by = 2047; end
         launch(bx, by, base + int'($urandom_range(0, 15)), base + int'($urandom_range(0, 15)),
                base + int'($urandom_range(0, 15)), base + int'($urandom_range(0, 15)));
         wait_idle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
